// File: rtl/uart_rx_parity_if.sv
// Character-side handshake of uart_rx_parity: holding-register outputs plus consumer ready.
interface uart_rx_parity_if #(
  parameter int DATA_BITS = 6
);
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 busy_o;

  modport master (
    output rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx_parity.sv
// UART receiver: start, DATA_BITS data (LSB first), even parity, stop; one-entry holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit, decided one cycle later.
module uart_rx_parity #(
  parameter int CLKS_PER_BIT = 208,
  parameter int DATA_BITS    = 6
) (
  input  logic clk,
  input  logic rstn,
  input  logic uart_rx,
  uart_rx_parity_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_PT = MID + 1'b1;
`else
  localparam logic [CW-1:0] START_PT = MID;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q;
  logic                 rx_meta_q, rxs_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q, busy_q;
  logic                 bit_s, tick, accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rxs_q     <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rxs from the two previous cycles, so at the decision
  // cycle (mid+1) it covers mid-1 and mid.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist_q <= '1;
    else       hist_q <= {hist_q[0], rxs_q};
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  assign bit_s = rxs_q;
`endif

  // START decides at the (voted) mid point; every later bit is exactly one bit time on.
  assign tick   = (state_q == START) ? (cnt_q == START_PT) : (cnt_q == LAST);
  assign accept = valid_q & bus.rx_ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            cnt_q <= '0;
            if (bit_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tick) begin
            cnt_q   <= '0;
            shift_q <= {bit_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IW'(DATA_BITS - 1)) state_q <= PARITY;
            else                             idx_q   <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        PARITY: begin
          if (tick) begin
            cnt_q   <= '0;
            par_q   <= bit_s;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (tick) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            // A same-cycle accept frees the register, so the reload wins over overrun.
            if (!valid_q || accept) begin
              data_q  <= shift_q;
              perr_q  <= (^shift_q) ^ par_q;
              ferr_q  <= ~bit_s;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data_o    = data_q;
  assign bus.rx_valid_o   = valid_q;
  assign bus.parity_err_o = perr_q;
  assign bus.frame_err_o  = ferr_q;
  assign bus.overrun_o    = ovr_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Self-checking bench for uart_rx_parity: frame driver, scoreboard queue, per-scenario tasks.
module tb_uart_rx_parity;

  localparam int CLKS = 208;
  localparam int DB   = 6;
  localparam int MID  = (CLKS - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SP = MID + 1;
`else
  localparam int SP = MID;
`endif
  localparam int FRAME = (DB + 3) * CLKS;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  logic clk;
  logic rstn;
  logic uart_rx;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  exp_t mon_e, mon_g;

  uart_rx_parity_if #(.DATA_BITS(DB)) bus ();

  uart_rx_parity #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DB)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Scoreboard: compare the held character whenever the consumer takes it.
  always begin
    @(negedge clk);
    #2;
    if (rstn && bus.rx_valid_o && bus.rx_ready_i) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data=%b pe=%b fe=%b, want no character",
                 bus.rx_data_o, bus.parity_err_o, bus.frame_err_o);
      end else begin
        mon_e = sb.pop_front();
        mon_g = '{d: bus.rx_data_o, pe: bus.parity_err_o, fe: bus.frame_err_o};
        if (mon_g !== mon_e) begin
          n_err++;
          $display("FAIL sb_char: got data=%b pe=%b fe=%b, want data=%b pe=%b fe=%b",
                   mon_g.d, mon_g.pe, mon_g.fe, mon_e.d, mon_e.pe, mon_e.fe);
        end
      end
    end
  end

  // Drives one frame, one drive step per negedge. inject flips the data bits for one
  // cycle at the point the receiver samples them; acc_at pulses ready for one cycle.
  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop,
                            input bit inject, input int acc_at);
    logic [DB+2:0] fr;
    logic          v;
    int            b;
    fr = {stop, p, d, 1'b0};
    for (int n = 0; n < FRAME; n++) begin
      @(negedge clk);
      b = n / CLKS;
      v = fr[b];
      if (inject && b >= 1 && b <= DB && n == 1 + MID + b * CLKS) v = ~v;
      uart_rx = v;
      if (n == acc_at)          bus.rx_ready_i = 1'b1;
      else if (n == acc_at + 1) bus.rx_ready_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      uart_rx = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    uart_rx = 1'b1;
    bus.rx_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    n_vec++; if (bus.rx_data_o !== '0)   begin n_err++; $display("FAIL rst_data: got %b want 0", bus.rx_data_o); end
    n_vec++; if (bus.rx_valid_o !== 0)   begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.rx_valid_o); end
    n_vec++; if (bus.parity_err_o !== 0) begin n_err++; $display("FAIL rst_perr: got %b want 0", bus.parity_err_o); end
    n_vec++; if (bus.frame_err_o !== 0)  begin n_err++; $display("FAIL rst_ferr: got %b want 0", bus.frame_err_o); end
    n_vec++; if (bus.overrun_o !== 0)    begin n_err++; $display("FAIL rst_ovr: got %b want 0", bus.overrun_o); end
    n_vec++; if (bus.busy_o !== 0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
    @(negedge clk);
    rstn = 1'b1;
    idle(10);
  endtask

  task automatic test_basic();
    bit seen;
    bus.rx_ready_i = 1'b1;
    sb.push_back('{d: 6'b001011, pe: 1'b0, fe: 1'b0});
    fork
      send_frame(6'b001011, 1'b1, 1'b1, 1'b0, -10);
      begin
        seen = 1'b0;
        for (int i = 0; i < FRAME + 200 && !seen; i++) begin
          @(negedge clk);
          #2;
          if (bus.rx_valid_o) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
          n_err++; $display("FAIL basic_valid_timeout: got no rx_valid_o, want rx_valid_o=1");
        end else begin
          @(negedge clk);
          #2;
          n_vec++;
          if (bus.rx_valid_o !== 1'b0) begin
            n_err++; $display("FAIL basic_valid_drop: got %b want 0", bus.rx_valid_o);
          end
        end
      end
    join
    idle(CLKS);
  endtask

  task automatic test_parity();
    bus.rx_ready_i = 1'b1;
    sb.push_back('{d: 6'b000101, pe: 1'b1, fe: 1'b0});
    send_frame(6'b000101, 1'b1, 1'b1, 1'b0, -10);
    idle(CLKS);
    sb.push_back('{d: 6'b010011, pe: 1'b0, fe: 1'b0});
    send_frame(6'b010011, 1'b1, 1'b1, 1'b0, -10);
    idle(CLKS);
  endtask

  task automatic test_frame_glitch();
    bit busy_seen;
    bus.rx_ready_i = 1'b1;
    sb.push_back('{d: 6'b101010, pe: 1'b0, fe: 1'b1});
    send_frame(6'b101010, 1'b1, 1'b0, 1'b0, -10);
    idle(2 * CLKS);
    #2;
    n_vec++;
    if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL ferr_rearm_busy: got %b want 0", bus.busy_o); end
    repeat (3) begin @(negedge clk); uart_rx = 1'b0; end
    busy_seen = 1'b0;
    for (int i = 0; i < 2 * CLKS; i++) begin
      @(negedge clk);
      uart_rx = 1'b1;
      #2;
      if (bus.busy_o) busy_seen = 1'b1;
    end
    n_vec++; if (!busy_seen)            begin n_err++; $display("FAIL glitch_busy_rise: got 0 want 1"); end
    n_vec++; if (bus.busy_o !== 1'b0)   begin n_err++; $display("FAIL glitch_busy: got %b want 0", bus.busy_o); end
    n_vec++; if (bus.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", bus.rx_valid_o); end
  endtask

  task automatic test_overrun();
    bus.rx_ready_i = 1'b0;
    sb.push_back('{d: 6'b110011, pe: 1'b0, fe: 1'b0});
    send_frame(6'b110011, 1'b0, 1'b1, 1'b0, -10);
    send_frame(6'b010101, 1'b1, 1'b1, 1'b0, -10);
    idle(2);
    #2;
    n_vec++; if (bus.rx_valid_o !== 1'b1)     begin n_err++; $display("FAIL ovr_valid: got %b want 1", bus.rx_valid_o); end
    n_vec++; if (bus.rx_data_o !== 6'b110011) begin n_err++; $display("FAIL ovr_held: got %b want 110011", bus.rx_data_o); end
    n_vec++; if (bus.overrun_o !== 1'b1)      begin n_err++; $display("FAIL ovr_set: got %b want 1", bus.overrun_o); end
    @(negedge clk); bus.rx_ready_i = 1'b1;
    @(negedge clk); bus.rx_ready_i = 1'b0;
    #2;
    n_vec++; if (bus.overrun_o !== 1'b0)  begin n_err++; $display("FAIL ovr_clear: got %b want 0", bus.overrun_o); end
    n_vec++; if (bus.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL ovr_consume: got %b want 0", bus.rx_valid_o); end
    idle(CLKS);
  endtask

  task automatic test_accept_on_stop();
    bus.rx_ready_i = 1'b0;
    sb.push_back('{d: 6'b100001, pe: 1'b0, fe: 1'b0});
    send_frame(6'b100001, 1'b0, 1'b1, 1'b0, -10);
    idle(CLKS);
    sb.push_back('{d: 6'b011100, pe: 1'b0, fe: 1'b0});
    send_frame(6'b011100, 1'b1, 1'b1, 1'b0, 3 + SP + (DB + 2) * CLKS);
    idle(2);
    #2;
    n_vec++; if (bus.rx_valid_o !== 1'b1)     begin n_err++; $display("FAIL aos_valid: got %b want 1", bus.rx_valid_o); end
    n_vec++; if (bus.rx_data_o !== 6'b011100) begin n_err++; $display("FAIL aos_data: got %b want 011100", bus.rx_data_o); end
    n_vec++; if (bus.overrun_o !== 1'b0)      begin n_err++; $display("FAIL aos_ovr: got %b want 0", bus.overrun_o); end
    @(negedge clk); bus.rx_ready_i = 1'b1;
    @(negedge clk); bus.rx_ready_i = 1'b0;
    idle(CLKS);
  endtask

  task automatic test_mid_reset();
    bus.rx_ready_i = 1'b0;
    send_frame(6'b101101, 1'b0, 1'b1, 1'b0, -10);
    idle(CLKS);
    fork
      send_frame(6'b111000, 1'b1, 1'b1, 1'b0, -10);
      begin
        repeat (4 * CLKS) @(negedge clk);
        rstn = 1'b0;
      end
    join
    #2;
    n_vec++; if (bus.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b want 0", bus.rx_valid_o); end
    n_vec++; if (bus.rx_data_o !== '0)    begin n_err++; $display("FAIL mrst_data: got %b want 0", bus.rx_data_o); end
    n_vec++; if (bus.busy_o !== 1'b0)     begin n_err++; $display("FAIL mrst_busy: got %b want 0", bus.busy_o); end
    idle(1);
    rstn = 1'b1;
    idle(CLKS);
    n_vec++; if (bus.busy_o !== 1'b0)     begin n_err++; $display("FAIL mrst_idle_busy: got %b want 0", bus.busy_o); end
    bus.rx_ready_i = 1'b1;
    sb.push_back('{d: 6'b011110, pe: 1'b0, fe: 1'b0});
    send_frame(6'b011110, 1'b0, 1'b1, 1'b0, -10);
    idle(CLKS);
  endtask

  task automatic test_majority();
    logic [DB-1:0] d;
    logic [DB-1:0] dn;
    d  = 6'b110100;
    dn = ~d;
    bus.rx_ready_i = 1'b1;
`ifdef UART_RX_MAJORITY_EN
    sb.push_back('{d: d, pe: (^d) ^ 1'b1, fe: 1'b0});
`else
    sb.push_back('{d: dn, pe: (^dn) ^ 1'b1, fe: 1'b0});
`endif
    send_frame(d, 1'b1, 1'b1, 1'b1, -10);
    idle(CLKS);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    uart_rx = 1'b1;
    bus.rx_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_frame_glitch();
    test_overrun();
    test_accept_on_stop();
    test_mid_reset();
    test_majority();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending characters, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
